// File: rtl/fp_stage_pipe.sv
// rtl/fp_stage_pipe.sv - clocked FP stage: single-cycle ALU, shift-add multiplier, held output
// Accepts one operand packet per cycle and emits a result packet plus data-memory controls.
module fp_stage_pipe #(
  parameter int DATA_W  = 16,
  parameter int COLOR_W = 3,
  parameter int GEN_W   = 8,
  parameter int DEST_W  = 9,
  parameter int OPC_W   = 5,
  localparam int IN_W   = COLOR_W + GEN_W + DEST_W + 4 + OPC_W + 2 + 2 * DATA_W,
  localparam int OUT_W  = COLOR_W + GEN_W + DEST_W + 4 + 2 + DATA_W
) (
  input  logic              CLK,
  input  logic              MR,
  input  logic              Send_in,
  output logic              Ack_out,
  input  logic [IN_W-1:0]   PACKET_IN,
  output logic              Send_out,
  input  logic              Ack_in,
  output logic [OUT_W-1:0]  PACKET_OUT,
  output logic              LOAD_FLG,
  output logic              WRITE_EN,
  output logic [DATA_W-1:0] WRITE_DATA,
  input  logic              DEL,
  output logic              ERR
);
  localparam int SH_W  = $clog2(DATA_W);
  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [OPC_W-1:0] OP_ADD    = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_ADDC   = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_SUB    = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_SUBC   = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_AND    = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_OR     = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_XOR    = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_MUL    = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_SHL    = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_SHR    = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_ROL    = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_ROR    = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_BZ     = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_BZL    = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_BNZ    = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_BNZL   = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_BC     = OPC_W'(16);
  localparam logic [OPC_W-1:0] OP_BNC    = OPC_W'(17);
  localparam logic [OPC_W-1:0] OP_LDM    = OPC_W'(18);
  localparam logic [OPC_W-1:0] OP_STM    = OPC_W'(19);
  localparam logic [OPC_W-1:0] OP_CHGCOL = OPC_W'(20);
  localparam logic [OPC_W-1:0] OP_ADDGEN = OPC_W'(21);
  localparam logic [OPC_W-1:0] OP_DECGEN = OPC_W'(22);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_OUT} state_t;
  state_t state;

  logic [COLOR_W-1:0] in_color;
  logic [GEN_W-1:0]   in_gen;
  logic [DEST_W-1:0]  in_dest;
  logic [3:0]         in_flags;
  logic [OPC_W-1:0]   in_opc;
  logic               in_c, in_z;
  logic [DATA_W-1:0]  in_l, in_r;
  assign {in_color, in_gen, in_dest, in_flags, in_opc, in_c, in_z, in_l, in_r} = PACKET_IN;

  logic [SH_W-1:0]     sh_amt;
  logic [2*DATA_W-1:0] shl_w, shr_w;
  assign sh_amt = in_r[SH_W-1:0];
  assign shl_w  = {{DATA_W{1'b0}}, in_l} << sh_amt;
  assign shr_w  = {in_l, {DATA_W{1'b0}}} >> sh_amt;

  logic [DATA_W-1:0]  alu_res;
  logic               alu_c, alu_z, z_pass, alu_load, alu_write, alu_def;
  logic [COLOR_W-1:0] alu_color;
  logic [GEN_W-1:0]   alu_gen;
  logic [DEST_W-1:0]  alu_dest;

  always_comb begin
    alu_res   = in_l;
    alu_c     = in_c;
    alu_z     = in_z;
    z_pass    = 1'b0;
    alu_color = in_color;
    alu_gen   = in_gen;
    alu_dest  = in_dest;
    alu_load  = 1'b0;
    alu_write = 1'b0;
    alu_def   = 1'b1;
    case (in_opc)
      OP_ADD, OP_ADDC:
        {alu_c, alu_res} = {1'b0, in_l} + {1'b0, in_r} + {{DATA_W{1'b0}}, in_c & (in_opc == OP_ADDC)};
      OP_SUB, OP_SUBC:
        {alu_c, alu_res} = {1'b0, in_l} - {1'b0, in_r} - {{DATA_W{1'b0}}, in_c & (in_opc == OP_SUBC)};
      OP_AND: begin alu_res = in_l & in_r; alu_c = 1'b0; end
      OP_OR:  begin alu_res = in_l | in_r; alu_c = 1'b0; end
      OP_XOR: begin alu_res = in_l ^ in_r; alu_c = 1'b0; end
      OP_MUL: alu_def = 1'b1;
      // Rotates reuse the shifter: the bits pushed out of one half are the bits that wrap.
      OP_SHL: begin alu_res = shl_w[DATA_W-1:0]; alu_c = |shl_w[2*DATA_W-1:DATA_W]; end
      OP_SHR: begin alu_res = shr_w[2*DATA_W-1:DATA_W]; alu_c = |shr_w[DATA_W-1:0]; end
      OP_ROL: begin
        alu_res = shl_w[DATA_W-1:0] | shl_w[2*DATA_W-1:DATA_W];
        alu_c   = |shl_w[2*DATA_W-1:DATA_W];
      end
      OP_ROR: begin
        alu_res = shr_w[2*DATA_W-1:DATA_W] | shr_w[DATA_W-1:0];
        alu_c   = |shr_w[DATA_W-1:0];
      end
      OP_BZ, OP_BZL:   begin z_pass = 1'b1; if (in_z)  alu_dest = in_dest + DEST_W'(1); end
      OP_BNZ, OP_BNZL: begin z_pass = 1'b1; if (!in_z) alu_dest = in_dest + DEST_W'(1); end
      OP_BC:           begin z_pass = 1'b1; if (in_c)  alu_dest = in_dest + DEST_W'(1); end
      OP_BNC:          begin z_pass = 1'b1; if (!in_c) alu_dest = in_dest + DEST_W'(1); end
      OP_LDM: begin z_pass = 1'b1; alu_res = in_l + in_r; alu_load = 1'b1; end
      OP_STM: begin z_pass = 1'b1; alu_res = in_l + in_r; alu_write = 1'b1; end
      OP_CHGCOL: alu_color = in_r[COLOR_W-1:0];
      OP_ADDGEN: alu_gen = in_gen + in_r[GEN_W-1:0];
      OP_DECGEN: alu_gen = in_gen - GEN_W'(1);
      default:   alu_def = 1'b0;
    endcase
    if (!z_pass) alu_z = (alu_res == '0);
  end

  logic [2*DATA_W-1:0] mul_a, prod, mul_sum;
  logic [DATA_W-1:0]   mul_b, mul_hi;
  logic [CNT_W-1:0]    cnt;
  logic                mul_c;
  assign mul_sum = prod + (mul_b[0] ? mul_a : '0);
  assign mul_hi  = mul_sum[2*DATA_W-1:DATA_W];
  assign mul_c   = ~((mul_hi == '0) | (&mul_hi));

  logic [OUT_W-1:0]  pkt_r;
  logic              load_r, write_r;
  logic [DATA_W-1:0] wdata_r;
  logic              accept;

  assign Ack_out    = (state == S_IDLE) | ((state == S_OUT) & Ack_in & ~DEL);
  assign accept     = Send_in & Ack_out;
  assign Send_out   = (state == S_OUT);
  assign PACKET_OUT = pkt_r;
  assign LOAD_FLG   = load_r & Send_out;
  assign WRITE_EN   = write_r & Send_out;
  assign WRITE_DATA = Send_out ? wdata_r : '0;

  always_ff @(posedge CLK) begin
    if (MR) begin
      state   <= S_IDLE;
      pkt_r   <= '0;
      load_r  <= 1'b0;
      write_r <= 1'b0;
      wdata_r <= '0;
      mul_a   <= '0;
      mul_b   <= '0;
      prod    <= '0;
      cnt     <= '0;
      ERR     <= 1'b0;
    end else begin
      ERR <= 1'b0;
      if (DEL) begin
        state <= S_IDLE;
      end else if (accept) begin
        wdata_r <= in_l;
        if (in_opc == OP_MUL) begin
          state   <= S_MUL;
          mul_a   <= {{DATA_W{1'b0}}, in_l};
          mul_b   <= in_r;
          prod    <= '0;
          cnt     <= CNT_W'(DATA_W);
          pkt_r   <= {in_color, in_gen, in_dest, in_flags, 2'b00, {DATA_W{1'b0}}};
          load_r  <= 1'b0;
          write_r <= 1'b0;
        end else if (alu_def) begin
          state   <= S_OUT;
          pkt_r   <= {alu_color, alu_gen, alu_dest, in_flags, alu_c, alu_z, alu_res};
          load_r  <= alu_load;
          write_r <= alu_write;
        end else begin
          state <= S_IDLE;
          ERR   <= 1'b1;
        end
      end else begin
        case (state)
          S_OUT: if (Ack_in) state <= S_IDLE;
          S_MUL: begin
            prod  <= mul_sum;
            mul_a <= mul_a << 1;
            mul_b <= mul_b >> 1;
            cnt   <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state              <= S_OUT;
              pkt_r[DATA_W+1:0]  <= {mul_c, (mul_sum[DATA_W-1:0] == '0), mul_sum[DATA_W-1:0]};
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_fp_stage_pipe.sv
// tb/tb_fp_stage_pipe.sv - self-checking bench for fp_stage_pipe against an arithmetic reference model
module tb_fp_stage_pipe;
  localparam int IN_W  = 63;
  localparam int OUT_W = 42;

  logic              CLK = 1'b0;
  logic              MR, Send_in, Ack_in, DEL;
  logic [IN_W-1:0]   PACKET_IN;
  logic              Ack_out, Send_out, LOAD_FLG, WRITE_EN, ERR;
  logic [OUT_W-1:0]  PACKET_OUT;
  logic [15:0]       WRITE_DATA;

  int checks = 0;
  int failures = 0;

  fp_stage_pipe dut (
    .CLK(CLK), .MR(MR), .Send_in(Send_in), .Ack_out(Ack_out), .PACKET_IN(PACKET_IN),
    .Send_out(Send_out), .Ack_in(Ack_in), .PACKET_OUT(PACKET_OUT), .LOAD_FLG(LOAD_FLG),
    .WRITE_EN(WRITE_EN), .WRITE_DATA(WRITE_DATA), .DEL(DEL), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  function automatic logic [IN_W-1:0] mk(input int color, gen, dest, fl, opc, c, z, l, r);
    logic [IN_W-1:0] p;
    p = {3'(color), 8'(gen), 9'(dest), 4'(fl), 5'(opc), 1'(c), 1'(z), 16'(l), 16'(r)};
    return p;
  endfunction

  // Opcode numbering: ADD..XOR 0-6, MUL 7, SHL/SHR/ROL/ROR 8-11, BZ BZL BNZ BNZL BC BNC 12-17,
  // LDM 18, STM 19, CHGCOL 20, ADDGEN 21, DECGEN 22; everything above is undefined.
  function automatic void model(input logic [IN_W-1:0] p, output bit def, output logic [OUT_W-1:0] o,
                                output bit ld, output bit wr, output int lat);
    int color, gen, dest, opc, c, z, li, ri, res, co, zo, sh, sr, s;
    bit zpass;
    longint pr, hi;
    logic [3:0] fl;
    color = int'(p[62:60]); gen = int'(p[59:52]); dest = int'(p[51:43]); fl = p[42:39];
    opc = int'(p[38:34]); c = int'(p[33]); z = int'(p[32]); li = int'(p[31:16]); ri = int'(p[15:0]);
    def = 1; ld = 0; wr = 0; zpass = 0; res = li; co = c; zo = z; sh = ri % 16;
    lat = (opc == 7) ? 17 : 1;
    case (opc)
      0: begin s = li + ri; res = s; co = int'(s > 65535); end
      1: begin s = li + ri + c; res = s; co = int'(s > 65535); end
      2: begin s = li - ri; res = s; co = int'(s < 0); end
      3: begin s = li - ri - c; res = s; co = int'(s < 0); end
      4: begin res = li & ri; co = 0; end
      5: begin res = li | ri; co = 0; end
      6: begin res = li ^ ri; co = 0; end
      7: begin
        pr = longint'(li) * longint'(ri); res = int'(pr % 65536); hi = pr / 65536;
        co = int'(!(hi == 0 || hi == 65535));
      end
      8:  begin res = li << sh; co = int'(sh != 0 && (li >> (16 - sh)) != 0); end
      9:  begin res = li >> sh; co = int'((li % (1 << sh)) != 0); end
      10: begin res = (li << sh) | (li >> (16 - sh)); co = int'(sh != 0 && (li >> (16 - sh)) != 0); end
      11: begin res = (li >> sh) | (li << (16 - sh)); co = int'((li % (1 << sh)) != 0); end
      12, 13: begin zpass = 1; if (z == 1) dest = (dest + 1) % 512; end
      14, 15: begin zpass = 1; if (z == 0) dest = (dest + 1) % 512; end
      16: begin zpass = 1; if (c == 1) dest = (dest + 1) % 512; end
      17: begin zpass = 1; if (c == 0) dest = (dest + 1) % 512; end
      18: begin zpass = 1; res = li + ri; ld = 1; end
      19: begin zpass = 1; res = li + ri; wr = 1; end
      20: color = ri % 8;
      21: begin sr = ri % 256; if (sr > 127) sr = sr - 256; gen = (gen + sr + 256) % 256; end
      22: gen = (gen + 255) % 256;
      default: def = 0;
    endcase
    res = res & 'hFFFF;
    if (!zpass) zo = int'(res == 0);
    o = {3'(color), 8'(gen), 9'(dest), fl, 1'(co), 1'(zo), 16'(res)};
  endfunction

  // Presents one packet from IDLE and watches the output side for up to 'bound' cycles.
  task automatic run_one(input logic [IN_W-1:0] p, input int bound, output bit got, output int lat,
                         output logic [OUT_W-1:0] o, output logic ld, output logic wr,
                         output logic [15:0] wd, output int ack_low, output int errs);
    got = 0; lat = 0; o = '0; ld = 0; wr = 0; wd = '0; ack_low = 0; errs = 0;
    @(negedge CLK);
    PACKET_IN = p; Send_in = 1'b1; Ack_in = 1'b1;
    @(posedge CLK); #1;
    Send_in = 1'b0;
    for (int i = 1; i <= bound && !got; i++) begin
      @(negedge CLK);
      if (ERR) errs++;
      if (Send_out) begin
        got = 1; lat = i; o = PACKET_OUT; ld = LOAD_FLG; wr = WRITE_EN; wd = WRITE_DATA;
      end else if (!Ack_out) ack_low++;
    end
  endtask

  task automatic test_reset;
    MR = 1'b1; Send_in = 1'b0; Ack_in = 1'b0; DEL = 1'b0; PACKET_IN = '0;
    repeat (2) @(posedge CLK);
    #1 MR = 1'b0;
    @(negedge CLK);
    checks++;
    if ({Send_out, LOAD_FLG, WRITE_EN, ERR, WRITE_DATA, PACKET_OUT} !== '0) begin
      failures++;
      $display("FAIL reset_outputs: got so=%b ld=%b wr=%b err=%b wd=%h pkt=%h, required all 0",
               Send_out, LOAD_FLG, WRITE_EN, ERR, WRITE_DATA, PACKET_OUT);
    end
    checks++;
    if (Ack_out !== 1'b1) begin failures++; $display("FAIL reset_ack: got %b required 1", Ack_out); end
  endtask

  task automatic test_add_carry;
    bit got, ed, eld, ewr; int lat, el, al, er; logic [OUT_W-1:0] o, eo; logic ld, wr; logic [15:0] wd;
    logic [IN_W-1:0] p;
    p = mk(2, 7, 'h33, 5, 0, 0, 0, 'hFFFF, 1);
    model(p, ed, eo, eld, ewr, el);
    run_one(p, 5, got, lat, o, ld, wr, wd, al, er);
    checks++;
    if (!got || lat != 1 || o[17:0] !== 18'h30000) begin
      failures++; $display("FAIL add_carry: got=%0d lat=%0d CZres=%h, required lat 1 CZres=30000", got, lat, o[17:0]);
    end
    checks++;
    if (o !== eo) begin failures++; $display("FAIL add_packet: got %h required %h", o, eo); end
  endtask

  task automatic test_mul;
    bit got; int lat, al, er; logic [OUT_W-1:0] o; logic ld, wr; logic [15:0] wd;
    run_one(mk(1, 3, 'h44, 9, 7, 0, 0, 'h0100, 'h0100), 25, got, lat, o, ld, wr, wd, al, er);
    checks++;
    if (!got || lat != 17 || al != 16 || o[17:0] !== 18'h30000) begin
      failures++;
      $display("FAIL mul_boundary: got=%0d lat=%0d ack_low=%0d CZres=%h, required lat 17 ack_low 16 CZres=30000",
               got, lat, al, o[17:0]);
    end
  endtask

  task automatic test_back_to_back;
    logic [IN_W-1:0] held, q[4]; logic [OUT_W-1:0] eo; bit ed, eld, ewr; int el;
    held = mk($urandom, $urandom, $urandom, $urandom, 0, $urandom, $urandom, $urandom, $urandom);
    model(held, ed, eo, eld, ewr, el);
    @(negedge CLK);
    PACKET_IN = held; Send_in = 1'b1; Ack_in = 1'b0;
    @(posedge CLK); #1;
    PACKET_IN = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLK);
      checks++;
      if (Send_out !== 1'b1 || PACKET_OUT !== eo || Ack_out !== 1'b0) begin
        failures++;
        $display("FAIL hold_cycle%0d: so=%b ack=%b pkt=%h, required so=1 ack=0 pkt=%h", i, Send_out, Ack_out, PACKET_OUT, eo);
      end
    end
    for (int i = 0; i < 4; i++)
      q[i] = mk($urandom, $urandom, $urandom, $urandom, 0, $urandom, $urandom, $urandom, $urandom);
    for (int i = 0; i < 4; i++) begin
      PACKET_IN = q[i]; Send_in = 1'b1; Ack_in = 1'b1;
      #1;
      checks++;
      if (Ack_out !== 1'b1) begin failures++; $display("FAIL stream_ack%0d: got %b required 1", i, Ack_out); end
      @(posedge CLK); #1;
      @(negedge CLK);
      model(q[i], ed, eo, eld, ewr, el);
      checks++;
      if (Send_out !== 1'b1 || PACKET_OUT !== eo) begin
        failures++; $display("FAIL stream_pkt%0d: so=%b pkt=%h, required so=1 pkt=%h", i, Send_out, PACKET_OUT, eo);
      end
    end
    Send_in = 1'b0;
    @(posedge CLK); #1;
    @(negedge CLK);
    checks++;
    if (Send_out !== 1'b0) begin failures++; $display("FAIL stream_drain: so=%b required 0", Send_out); end
  endtask

  task automatic test_branch_mem;
    bit got; int lat, al, er; logic [OUT_W-1:0] o; logic ld, wr; logic [15:0] wd;
    run_one(mk(0, 0, 'h1FF, 0, 12, 0, 1, 'h1234, 0), 5, got, lat, o, ld, wr, wd, al, er);
    checks++;
    if (!got || o[30:22] !== 9'h000 || o[15:0] !== 16'h1234 || o[16] !== 1'b1) begin
      failures++; $display("FAIL bz_wrap: dest=%h res=%h z=%b, required dest 000 res 1234 z 1", o[30:22], o[15:0], o[16]);
    end
    run_one(mk(0, 0, 'h010, 0, 14, 0, 1, 'h0055, 0), 5, got, lat, o, ld, wr, wd, al, er);
    checks++;
    if (!got || o[30:22] !== 9'h010) begin
      failures++; $display("FAIL bnz_not_taken: dest=%h required 010", o[30:22]);
    end
    run_one(mk(0, 0, 'h020, 0, 19, 1, 0, 5, 3), 5, got, lat, o, ld, wr, wd, al, er);
    checks++;
    if (!got || o[15:0] !== 16'd8 || wr !== 1'b1 || ld !== 1'b0 || wd !== 16'd5 || o[17:16] !== 2'b10) begin
      failures++;
      $display("FAIL stm: res=%h wr=%b ld=%b wd=%h cz=%b, required res 0008 wr 1 ld 0 wd 0005 cz 10", o[15:0], wr, ld, wd, o[17:16]);
    end
    run_one(mk(0, 0, 'h020, 0, 18, 0, 1, 'h0100, 'h0001), 5, got, lat, o, ld, wr, wd, al, er);
    checks++;
    if (!got || o[15:0] !== 16'h0101 || ld !== 1'b1 || wr !== 1'b0) begin
      failures++; $display("FAIL ldm: res=%h ld=%b wr=%b, required res 0101 ld 1 wr 0", o[15:0], ld, wr);
    end
  endtask

  task automatic test_del;
    bit got, ed, eld, ewr; int lat, al, er, seen, el; logic [OUT_W-1:0] o, eo; logic ld, wr; logic [15:0] wd;
    logic [IN_W-1:0] p;
    @(negedge CLK);
    PACKET_IN = mk(3, 3, 3, 3, 7, 0, 0, 'h1234, 'h5678); Send_in = 1'b1; Ack_in = 1'b1;
    @(posedge CLK); #1;
    Send_in = 1'b0;
    repeat (8) @(negedge CLK);
    DEL = 1'b1;
    @(posedge CLK); #1;
    DEL = 1'b0;
    seen = 0;
    @(negedge CLK);
    checks++;
    if (Ack_out !== 1'b1) begin failures++; $display("FAIL del_idle: ack=%b required 1", Ack_out); end
    for (int i = 0; i < 20; i++) begin
      if (Send_out) seen++;
      @(negedge CLK);
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL del_no_output: send_out cycles=%0d required 0", seen); end
    p = mk(1, 2, 3, 4, 0, 0, 0, 'h0F0F, 'h0101);
    model(p, ed, eo, eld, ewr, el);
    run_one(p, 5, got, lat, o, ld, wr, wd, al, er);
    checks++;
    if (!got || lat != 1 || o !== eo) begin
      failures++; $display("FAIL del_next_add: got=%0d lat=%0d pkt=%h, required lat 1 pkt=%h", got, lat, o, eo);
    end
  endtask

  task automatic test_mr_mid_mul;
    int seen;
    @(negedge CLK);
    PACKET_IN = mk(7, 'hAA, 'h155, 'hF, 7, 1, 1, 'hFFFF, 'hFFFF); Send_in = 1'b1; Ack_in = 1'b1;
    @(posedge CLK); #1;
    Send_in = 1'b0;
    repeat (5) @(negedge CLK);
    MR = 1'b1;
    @(posedge CLK); #1;
    MR = 1'b0;
    @(negedge CLK);
    checks++;
    if ({Send_out, LOAD_FLG, WRITE_EN, ERR, WRITE_DATA, PACKET_OUT} !== '0 || Ack_out !== 1'b1) begin
      failures++;
      $display("FAIL mr_mid_mul: so=%b err=%b pkt=%h ack=%b, required so 0 err 0 pkt 0 ack 1", Send_out, ERR, PACKET_OUT, Ack_out);
    end
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      if (Send_out) seen++;
    end
    checks++;
    if (seen != 0) begin failures++; $display("FAIL mr_no_output: send_out cycles=%0d required 0", seen); end
  endtask

  task automatic test_undefined;
    bit got, ed, eld, ewr; int lat, al, er, el; logic [OUT_W-1:0] o, eo; logic ld, wr; logic [15:0] wd;
    logic [IN_W-1:0] p;
    run_one(mk(1, 1, 1, 1, 25, 0, 0, 'h1111, 'h2222), 4, got, lat, o, ld, wr, wd, al, er);
    checks++;
    if (got || er != 1) begin
      failures++; $display("FAIL undefined_opc: send_out=%0d err_cycles=%0d, required 0 and 1", got, er);
    end
    p = mk(1, 'h01, 'h0AB, 2, 21, 1, 0, 'h0000, 'h00FE);
    model(p, ed, eo, eld, ewr, el);
    run_one(p, 5, got, lat, o, ld, wr, wd, al, er);
    checks++;
    if (!got || o[38:31] !== 8'hFF || o !== eo) begin
      failures++; $display("FAIL addgen_wrap: gen=%h pkt=%h, required gen ff pkt=%h", o[38:31], o, eo);
    end
  endtask

  task automatic test_random;
    bit got, ed, eld, ewr; int lat, al, er, el; logic [OUT_W-1:0] o, eo; logic ld, wr; logic [15:0] wd;
    logic [IN_W-1:0] p;
    for (int n = 0; n < 48; n++) begin
      p = mk($urandom, $urandom, $urandom, $urandom, $urandom_range(0, 27), $urandom, $urandom,
             $urandom, $urandom);
      model(p, ed, eo, eld, ewr, el);
      run_one(p, 20, got, lat, o, ld, wr, wd, al, er);
      checks++;
      if (ed) begin
        if (!got || lat != el || o !== eo || ld !== eld || wr !== ewr || wd !== p[31:16] || er != 0) begin
          failures++;
          $display("FAIL random%0d opc=%0d: got=%0d lat=%0d pkt=%h ld=%b wr=%b wd=%h, required lat %0d pkt=%h ld=%b wr=%b wd=%h",
                   n, p[38:34], got, lat, o, ld, wr, wd, el, eo, eld, ewr, p[31:16]);
        end
      end else if (got || er != 1) begin
        failures++; $display("FAIL random%0d undef opc=%0d: send_out=%0d err_cycles=%0d, required 0 and 1", n, p[38:34], got, er);
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_add_carry;
    test_mul;
    test_back_to_back;
    test_branch_mem;
    test_del;
    test_mr_mid_mul;
    test_undefined;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
